led_mode_ctrl: RTL
==================

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL have parameter DB_CYC, default 1_000_000: consecutive cycles a new key level must persist to be accepted (20 ms at 50 MHz).
REQ-002 SHALL have parameter SLOW_HALF, default 25_000_000: half-period, in cycles, of slow blink.
REQ-003 SHALL have parameter FAST_HALF, default 5_000_000: half-period, in cycles, of fast blink.
REQ-004 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port key_in  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk.
REQ-007 SHALL have port led_out  output  1  LED drive, 1 = lit, registered.
REQ-008 SHALL have port mode  output  2  current mode: 00 OFF, 01 ON, 10 SLOW, 11 FAST, registered.
REQ-009 SHALL have port press_pulse  output  1  one-cycle strobe per accepted key press, registered.

Function
REQ-010 SHALL pass key_in through a 2-flop synchronizer; the output of the second flop is key_sync.
REQ-011 SHALL hold a debounced level key_stable and a counter db_cnt sized for DB_CYC.
REQ-012 SHALL clear db_cnt to 0 in every cycle where key_sync equals key_stable.
REQ-013 SHALL increment db_cnt in every cycle where key_sync differs from key_stable. When db_cnt equals DB_CYC-1 in such a cycle, key_stable SHALL take key_sync at that edge and db_cnt SHALL clear.
REQ-014 SHALL reject any key level change lasting fewer than DB_CYC consecutive key_sync cycles, leaving key_stable unchanged.
REQ-015 SHALL assert press_pulse for exactly one cycle, starting at the same edge where key_stable goes 1->0.
REQ-016 SHALL NOT generate press_pulse when key_stable goes 0->1 (release).
REQ-017 SHALL, in the cycle after press_pulse, advance mode cyclically: OFF->ON->SLOW->FAST->OFF.
REQ-018 SHALL advance mode by exactly one step per press_pulse, whatever the press duration.
REQ-019 SHALL run a blink counter blk_cnt and a phase bit blk_ph only in SLOW and FAST.
REQ-020 SHALL count blk_cnt from 0 to HALF-1, where HALF is SLOW_HALF in SLOW and FAST_HALF in FAST.
REQ-021 SHALL, at the edge where blk_cnt equals HALF-1, toggle blk_ph and wrap blk_cnt to 0.
REQ-022 SHALL, on every mode change, set blk_cnt to 0 and blk_ph to 1 at the same edge as the change.
REQ-023 SHALL hold blk_cnt at 0 and blk_ph at 1 in OFF and ON.
REQ-024 SHALL register led_out from the current mode:
  - OFF: 0
  - ON: 1
  - SLOW and FAST: blk_ph
REQ-025 SHALL update led_out one cycle after the mode edge.
REQ-026 SHALL, when key_in falls and stays low, assert press_pulse 2+DB_CYC edges after the first edge that samples key_in low.
REQ-027 SHALL, if a press arrives while blinking, apply the REQ-022 restart in the new mode with no residual phase from the old mode.
REQ-028 SHALL size all counters so that no parameter value up to 2^26 can overflow them.

Reset
REQ-029 SHALL, when rst_n is sampled low at any edge, including mid-debounce or mid-blink, force the following on that edge:
  - synchronizer flops and key_stable to 1
  - db_cnt and blk_cnt to 0
  - blk_ph to 1
  - mode to 00
  - led_out to 0
  - press_pulse to 0
REQ-030 SHALL resume normal operation on the first edge with rst_n high, treating a key held low through reset as a new press once debounced.

Verification (DB_CYC=4, SLOW_HALF=8, FAST_HALF=2)
REQ-031 SHALL check: hold rst_n=0 for 3 cycles -> led_out=0, mode=00, press_pulse=0.
REQ-032 SHALL check: key_in low for 3 cycles, then high -> no press_pulse, mode stays 00.
REQ-033 SHALL check: key_in held low -> press_pulse high exactly 1 cycle, 6 edges after first low sample, then mode=01 and led_out=1 one cycle later; release gives no pulse.
REQ-034 SHALL check: second debounced press -> mode=10, and led_out toggles every 8 cycles, starting lit.
REQ-035 SHALL check: third press mid-blink -> mode=11, led_out restarts lit, then toggles every 2 cycles; fourth press -> mode=00, led_out=0.
REQ-036 SHALL check: assert rst_n=0 during FAST blink with key held low -> all outputs return to reset values the same edge; after release of reset, held key yields one press_pulse after 6 edges.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// Push-button LED mode controller: synchronizes and debounces an active-low key,
// steps OFF -> ON -> SLOW -> FAST on each accepted press and drives the LED.
module led_mode_ctrl #(
  parameter int unsigned DB_CYC    = 1_000_000,
  parameter int unsigned SLOW_HALF = 25_000_000,
  parameter int unsigned FAST_HALF = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       press_pulse
);

  // 27 bits holds any terminal count for parameters up to 2^26.
  localparam int unsigned CW = 27;

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_HALF - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_HALF - 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ON   = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  logic          sync1_q;
  logic          sync2_q;
  logic          key_stable_q;
  logic          key_stable_d;
  logic [CW-1:0] db_cnt_q;
  logic [CW-1:0] db_cnt_d;
  logic          press_pulse_q;
  logic          press_pulse_d;

  mode_e         mode_q;
  logic [CW-1:0] blk_cnt_q;
  logic          blk_ph_q;
  logic          led_q;
  logic [CW-1:0] half_last;

  // A level change is accepted on its DB_CYC-th consecutive differing cycle.
  always_comb begin
    key_stable_d  = key_stable_q;
    db_cnt_d      = '0;
    press_pulse_d = 1'b0;
    if (sync2_q != key_stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_stable_d  = sync2_q;
        press_pulse_d = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      key_stable_q  <= 1'b1;
      db_cnt_q      <= '0;
      press_pulse_q <= 1'b0;
    end else begin
      sync1_q       <= key_in;
      sync2_q       <= sync1_q;
      key_stable_q  <= key_stable_d;
      db_cnt_q      <= db_cnt_d;
      press_pulse_q <= press_pulse_d;
    end
  end

  assign half_last = (mode_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= MODE_OFF;
      blk_cnt_q <= '0;
      blk_ph_q  <= 1'b1;
      led_q     <= 1'b0;
    end else begin
      case (mode_q)
        MODE_OFF: led_q <= 1'b0;
        MODE_ON:  led_q <= 1'b1;
        default:  led_q <= blk_ph_q;
      endcase

      if (press_pulse_q) begin
        case (mode_q)
          MODE_OFF:  mode_q <= MODE_ON;
          MODE_ON:   mode_q <= MODE_SLOW;
          MODE_SLOW: mode_q <= MODE_FAST;
          default:   mode_q <= MODE_OFF;
        endcase
        // Every mode change restarts the blink lit, with no carried phase.
        blk_cnt_q <= '0;
        blk_ph_q  <= 1'b1;
      end else if (mode_q == MODE_SLOW || mode_q == MODE_FAST) begin
        if (blk_cnt_q == half_last) begin
          blk_cnt_q <= '0;
          blk_ph_q  <= ~blk_ph_q;
        end else begin
          blk_cnt_q <= blk_cnt_q + CW'(1);
        end
      end else begin
        blk_cnt_q <= '0;
        blk_ph_q  <= 1'b1;
      end
    end
  end

  assign led_out     = led_q;
  assign mode        = mode_q;
  assign press_pulse = press_pulse_q;

endmodule
